// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings and the
// control FSM state type.
package alu_pkg;

    localparam logic [2:0] MODE_ADD = 3'd0;
    localparam logic [2:0] MODE_SUB = 3'd1;
    localparam logic [2:0] MODE_AND = 3'd2;
    localparam logic [2:0] MODE_OR  = 3'd3;
    localparam logic [2:0] MODE_XOR = 3'd4;
    localparam logic [2:0] MODE_MUL = 3'd5;
    localparam logic [2:0] MODE_SHL = 3'd6;
    localparam logic [2:0] MODE_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: loads on start, then retires one
// multiplier bit per cycle for WIDTH cycles; done stays high until reloaded.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q && (cnt_q != '0)) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: captures an operation, computes it (one cycle, or
// WIDTH+1 cycles for MUL) and holds a registered result until drained.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         mode_q;
    logic [WIDTH-1:0]   alu_out_q;
    logic               c_q;
    logic               z_q;
    logic               v_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   res_d;
    logic               c_d;
    logic               v_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    // Gated by rst_n so upstream never sees a handshake while reset is held.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign mul_start = in_valid && in_ready && (mode == MODE_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (left),
        .b       (right),
        .done    (mul_done),
        .product (product)
    );

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        diff  = {1'b0, a_q} - {1'b0, b_q};
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (mode_q)
            MODE_ADD: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            MODE_SUB: begin
                res_d = diff[WIDTH-1:0];
                c_d   = diff[WIDTH];
                v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            MODE_AND: res_d = a_q & b_q;
            MODE_OR:  res_d = a_q | b_q;
            MODE_XOR: res_d = a_q ^ b_q;
            MODE_MUL: begin
                res_d = product[WIDTH-1:0];
                c_d   = |product[2*WIDTH-1:WIDTH];
            end
            MODE_SHL: res_d = a_q << b_q[SHW-1:0];
            MODE_SHR: res_d = a_q >> b_q[SHW-1:0];
            default:  res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_ADD;
            alu_out_q   <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= left;
                        b_q     <= right;
                        mode_q  <= mode;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Non-MUL ops spend exactly one cycle here computing from the captured operands.
                    if ((mode_q != MODE_MUL) || mul_done) begin
                        alu_out_q   <= res_d;
                        c_q         <= c_d;
                        z_q         <= (res_d == '0);
                        v_q         <= v_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed WIDTH=8 cases, backpressure and
// mid-MUL reset, plus random ADD/SUB/MUL sweeps at WIDTH=4 and WIDTH=16.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] left;
    logic [7:0] right;
    logic [2:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic       flag_c;
    logic       flag_z;
    logic       flag_v;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    logic sweep_go = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left      (left),
        .right     (right),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Independent reference for a w-bit ALU using 64-bit arithmetic.
    function automatic void ref_model(input int w, input logic [2:0] m,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output exp_t e);
        longint unsigned mask, aa, bb, full, amt;
        logic sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        aa   = 64'(a) & mask;
        bb   = 64'(b) & mask;
        amt  = bb & ((64'd1 << $clog2(w)) - 64'd1);
        full = 64'd0;
        e.c  = 1'b0;
        e.v  = 1'b0;
        case (m)
            MODE_ADD: begin full = aa + bb; e.c = ((full >> w) & 64'd1) != 0; end
            MODE_SUB: begin full = (aa - bb) & mask; e.c = aa < bb; end
            MODE_AND: full = aa & bb;
            MODE_OR:  full = aa | bb;
            MODE_XOR: full = aa ^ bb;
            MODE_MUL: begin full = aa * bb; e.c = (full >> w) != 0; end
            MODE_SHL: full = aa << amt;
            default:  full = aa >> amt;
        endcase
        e.res = 32'(full & mask);
        sa = ((aa >> (w - 1)) & 64'd1) != 0;
        sb = ((bb >> (w - 1)) & 64'd1) != 0;
        sr = ((64'(e.res) >> (w - 1)) & 64'd1) != 0;
        if (m == MODE_ADD) e.v = (sa == sb) && (sr != sa);
        if (m == MODE_SUB) e.v = (sa != sb) && (sr != sa);
        e.z   = (e.res == 32'd0);
        e.lat = (m == MODE_MUL) ? w + 1 : 1;
    endfunction

    task automatic issue(input logic [2:0] m, input logic [7:0] l, input logic [7:0] r);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mode     = m;
        left     = l;
        right    = r;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        int   cyc = 0;
        exp_t e;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_res"}, 32'(alu_out), e.res);
        check({tag, "_c"},   32'(flag_c),  32'(e.c));
        check({tag, "_z"},   32'(flag_z),  32'(e.z));
        check({tag, "_v"},   32'(flag_v),  32'(e.v));
        check({tag, "_lat"}, 32'(cyc),     32'(e.lat));
        if (hold > 0) begin
            in_valid = 1'b1;
            mode     = MODE_ADD;
            left     = 8'h01;
            right    = 8'h01;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_res"},   32'(alu_out),   e.res);
            check({tag, "_hold_flags"}, 32'({flag_c, flag_z, flag_v}), 32'({e.c, e.z, e.v}));
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] l,
                          input logic [7:0] r, input logic [7:0] er, input logic ec,
                          input logic ez, input logic ev, input int hold);
        exp_t e;
        e.res = 32'(er);
        e.c   = ec;
        e.z   = ez;
        e.v   = ev;
        e.lat = (m == MODE_MUL) ? 9 : 1;
        exp_q.push_back(e);
        issue(m, l, r);
        collect(tag, hold);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 4 : 16;
        logic         in_valid_s  = 1'b0;
        logic         in_ready_s;
        logic [W-1:0] left_s      = '0;
        logic [W-1:0] right_s     = '0;
        logic [2:0]   mode_s      = MODE_ADD;
        logic         out_valid_s;
        logic         out_ready_s = 1'b1;
        logic [W-1:0] alu_out_s;
        logic         c_s;
        logic         z_s;
        logic         v_s;
        logic         done_s      = 1'b0;

        alu_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s),
            .in_ready  (in_ready_s),
            .left      (left_s),
            .right     (right_s),
            .mode      (mode_s),
            .out_valid (out_valid_s),
            .out_ready (out_ready_s),
            .alu_out   (alu_out_s),
            .flag_c    (c_s),
            .flag_z    (z_s),
            .flag_v    (v_s)
        );

        initial begin : p_sweep
            exp_t        e;
            exp_t        sq[$];
            logic [31:0] a, b, mask;
            logic [2:0]  m;
            int          cyc, n;
            mask = 32'((64'd1 << W) - 64'd1);
            wait (sweep_go);
            for (int i = 0; i < 15; i++) begin
                m = (i % 3 == 0) ? MODE_ADD : ((i % 3 == 1) ? MODE_SUB : MODE_MUL);
                a = $urandom() & mask;
                b = $urandom() & mask;
                if (i < 3) begin
                    a = mask;
                    b = (i == 1) ? mask : 32'd1;
                end
                ref_model(W, m, a, b, e);
                sq.push_back(e);
                n = 0;
                while (!in_ready_s && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("w%0d_ready", W), 32'(in_ready_s), 32'd1);
                in_valid_s = 1'b1;
                mode_s     = m;
                left_s     = a[W-1:0];
                right_s    = b[W-1:0];
                @(negedge clk);
                in_valid_s = 1'b0;
                cyc = 0;
                while (!out_valid_s && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                e = sq.pop_front();
                check($sformatf("w%0d_op%0d_res", W, i),   32'(alu_out_s), e.res);
                check($sformatf("w%0d_op%0d_flags", W, i), 32'({c_s, z_s, v_s}), 32'({e.c, e.z, e.v}));
                check($sformatf("w%0d_op%0d_lat", W, i),   32'(cyc), 32'(e.lat));
            end
            done_s = 1'b1;
        end
    end

    initial begin
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = MODE_ADD;
        left      = '0;
        right     = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_out",   32'(alu_out),   32'd0);
        check("rst_flags",     32'({flag_c, flag_z, flag_v}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready",  32'(in_ready),  32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);

        run_op("add",      MODE_ADD, 8'd10,  8'd22,  8'd32,  1'b0, 1'b0, 1'b0, 0);
        run_op("sub",      MODE_SUB, 8'd20,  8'd12,  8'd8,   1'b0, 1'b0, 1'b0, 0);
        run_op("and",      MODE_AND, 8'h65,  8'h59,  8'h41,  1'b0, 1'b0, 1'b0, 0);
        run_op("or",       MODE_OR,  8'h69,  8'h5B,  8'h7B,  1'b0, 1'b0, 1'b0, 0);
        run_op("add_wrap", MODE_ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1, 1'b0, 0);
        run_op("add_ovf",  MODE_ADD, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b0, 1'b1, 0);
        run_op("sub_brw",  MODE_SUB, 8'h05,  8'h09,  8'hFC,  1'b1, 1'b0, 1'b0, 0);
        run_op("mul",      MODE_MUL, 8'd13,  8'd11,  8'h8F,  1'b0, 1'b0, 1'b0, 0);
        run_op("mul_hi",   MODE_MUL, 8'h20,  8'h10,  8'h00,  1'b1, 1'b1, 1'b0, 0);
        run_op("shl",      MODE_SHL, 8'h81,  8'd1,   8'h02,  1'b0, 1'b0, 1'b0, 0);
        run_op("shr",      MODE_SHR, 8'h81,  8'd9,   8'h40,  1'b0, 1'b0, 1'b0, 0);
        run_op("xor",      MODE_XOR, 8'hF0,  8'hFF,  8'h0F,  1'b0, 1'b0, 1'b0, 0);
        run_op("bp",       MODE_SUB, 8'h05,  8'h09,  8'hFC,  1'b1, 1'b0, 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_no_phantom", 32'(out_valid), 32'd0);
        end

        // Reset four cycles into a MUL: the operation must vanish entirely.
        issue(MODE_MUL, 8'd13, 8'd11);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_alu_out",   32'(alu_out),   32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_rel_ready", 32'(in_ready),  32'd1);
        for (int i = 0; i < 8; i++) begin
            check("mrst_no_stale", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        run_op("post_rst", MODE_ADD, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0, 0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        sweep_go = 1'b1;
        k = 0;
        while (!(g_sweep[0].done_s && g_sweep[1].done_s) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("sweep_done", 32'({g_sweep[0].done_s, g_sweep[1].done_s}), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU: a WIDTH-bit ALU with eight modes, registered result and status flags, and an iterative multiplier. It sits between an operand-issue stage and a result consumer. Both sides use valid/ready handshakes, so it can stall on backpressure and run multi-cycle operations without a global enable.

## Interface
Parameters:
- WIDTH, 8, operand/result width; legal range 4..32.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept an operation.
- left  in  WIDTH  first operand.
- right  in  WIDTH  second operand; shift amount for SHL/SHR.
- mode  in  3  operation select (see Operation).
- out_valid  out  1  alu_out and flags are valid.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  WIDTH  result.
- flag_c  out  1  carry/borrow/high-part flag.
- flag_z  out  1  alu_out equals zero.
- flag_v  out  1  signed overflow.

## Operation
Mode encodings:
- 0 ADD: left+right.
- 1 SUB: left-right.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 MUL: low WIDTH bits of left*right, unsigned.
- 6 SHL: left<<right[$clog2(WIDTH)-1:0].
- 7 SHR: left>>right[$clog2(WIDTH)-1:0], logical.

Flag rules:
- ADD: flag_c = carry-out of the WIDTH+1-bit sum.
- SUB: flag_c = borrow, i.e. left<right unsigned.
- ADD/SUB: flag_v = signed two's-complement overflow.
- MUL: flag_c = 1 if the high WIDTH bits of the 2*WIDTH product are nonzero; flag_v = 0.
- Logic ops and shifts: flag_c = 0, flag_v = 0.
- All modes: flag_z = (alu_out == 0).

FSM:
- IDLE: in_ready=1. On in_valid&&in_ready, operands and mode are captured. MUL goes to BUSY. All other modes compute and go to DONE.
- BUSY: shift-add multiply, one bit of right per cycle, for exactly WIDTH cycles, then DONE. in_ready=0.
- DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Reset (rst_n=0 at an edge), from any state including mid-MUL: go to IDLE, discard the operation. alu_out, flags, out_valid and internal accumulators all become 0.
- in_ready is 0 in any cycle where rst_n is low.

## Timing
- Non-MUL ops: accept at edge N, out_valid high after edge N+1 (1-cycle latency).
- MUL: accept at edge N, out_valid high after edge N+WIDTH+1.
- Result handshake and next acceptance:
  - The result handshake completes at edge M; in_ready rises after M.
  - The next accept is no earlier than edge M+1, so maximum throughput is one non-MUL op per 2 cycles.
  - There is no same-cycle result-drain/accept overlap.
- in_valid while in_ready=0 is ignored; the upstream source must hold it.
- out_valid never drops without out_ready. alu_out and flags do not change while out_valid=1 && out_ready=0.
- Reset values: in_ready=0 during reset, then 1 the cycle after release. out_valid=0, alu_out=0, flag_c=0, flag_z=0, flag_v=0.

## Structure
- Shared package alu_pkg holds:
  - Mode constants MODE_ADD..MODE_SHR (3-bit).
  - FSM state enum ST_IDLE/ST_BUSY/ST_DONE.
- Sub-module alu_mul_iter(WIDTH):
  - Inputs: start, a, b.
  - Outputs: done, product[2*WIDTH-1:0].
  - Contains the shift-add datapath and bit counter.
  - Synchronous clear on rst_n.
- The top contains the FSM, single-cycle datapath, flag logic and output registers.

## Test plan
- WIDTH=8 basic ops:
  - ADD 10,22 -> 32, c=0 z=0 v=0.
  - SUB 20,12 -> 8, c=0.
  - AND 0x65,0x59 -> 0x41.
  - OR 0x69,0x5B -> 0x7B.
  - Each result has out_valid one cycle after accept.
- Flag edges:
  - ADD 0xFF,0x01 -> 0x00, c=1 z=1 v=0.
  - ADD 0x7F,0x01 -> 0x80, v=1.
  - SUB 0x05,0x09 -> 0xFC, c=1.
- MUL 13,11 -> 0x8F, c=0, out_valid exactly 9 cycles after accept. MUL 0x20,0x10 -> 0x00, c=1 z=1.
- Shifts: SHL 0x81 by 1 -> 0x02. SHR 0x81 by 9 (amount uses low 3 bits = 1) -> 0x40. XOR 0xF0,0xFF -> 0x0F.
- Backpressure: hold out_ready=0 for 5 cycles after a result. alu_out/flags must stay stable, in_ready=0, and a new in_valid is not accepted. Release it and check in_ready rises the next cycle.
- Reset mid-MUL: pull rst_n low 4 cycles into a MUL. The next edge gives out_valid=0 and alu_out=0. After release, ADD 1,2 -> 3 with no stale result emitted.
- Parameter sweep: repeat ADD/SUB/MUL at WIDTH=4 and WIDTH=16 against a reference model using random operands.
